// File: rtl/piso_serializer_pkg.sv
// Shared types for the PISO serializer.
// PISO_PARITY_EN adds a trailing even-parity bit per word.
package piso_pkg;

  localparam int unsigned PISO_DW = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

endpackage

// File: rtl/piso_serializer_if.sv
// Word-in / bit-out bundle of the PISO serializer.
// slave is the serializer side, master the producer/consumer side.
interface piso_serializer_if #(
  parameter int unsigned DATA_WIDTH = 16
);

  logic [DATA_WIDTH-1:0] din;
  logic                  din_valid;
  logic                  din_ready;
  logic                  dout;
  logic                  dout_valid;
  logic                  last;

  modport slave (
    input  din,
    input  din_valid,
    output din_ready,
    output dout,
    output dout_valid,
    output last
  );

  modport master (
    output din,
    output din_valid,
    input  din_ready,
    input  dout,
    input  dout_valid,
    input  last
  );

endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter, MSB first, valid/ready input.
// Define PISO_PARITY_EN to append an even-parity bit per word.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PISO_DW
) (
  input  logic clk,
  input  logic resetn,
  piso_serializer_if.slave bus
);

  localparam int unsigned CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  state_e                state_q;
  logic [DATA_WIDTH-1:0] sreg_q;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_d;
  logic                  dout_q;
  logic                  dval_q;
  logic                  last_q;
  logic                  fin;
  logic                  accept;

  assign cnt_d = cnt_q + CW'(1);
  assign fin   = (state_q == SHIFT) && (cnt_q == CNT_LAST);

`ifdef PISO_PARITY_EN
  logic par_q;

  assign bus.din_ready = (state_q == IDLE) ||
                         (state_q == PARITY);
`else
  assign bus.din_ready = (state_q == IDLE) || fin;
`endif

  assign accept = bus.din_valid && bus.din_ready;

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dval_q;
  assign bus.last       = last_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      dval_q  <= 1'b0;
      last_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else if (accept) begin
      state_q <= SHIFT;
      sreg_q  <= bus.din;
      cnt_q   <= '0;
      dout_q  <= bus.din[DATA_WIDTH-1];
      dval_q  <= 1'b1;
      last_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= ^bus.din;
`endif
    end else begin
      unique case (state_q)
        SHIFT: begin
          if (!fin) begin
            sreg_q <= sreg_q << 1;
            dout_q <= sreg_q[DATA_WIDTH-2];
            cnt_q  <= cnt_d;
`ifdef PISO_PARITY_EN
            last_q <= 1'b0;
`else
            last_q <= (cnt_d == CNT_LAST);
`endif
          end else begin
`ifdef PISO_PARITY_EN
            state_q <= PARITY;
            dout_q  <= par_q;
            last_q  <= 1'b1;
`else
            state_q <= IDLE;
            dout_q  <= 1'b0;
            dval_q  <= 1'b0;
            last_q  <= 1'b0;
`endif
          end
        end
        PARITY: begin
          state_q <= IDLE;
          dout_q  <= 1'b0;
          dval_q  <= 1'b0;
          last_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: vector table plus scoreboard.
// Build with PISO_PARITY_EN to cover the parity variant.
module tb_piso_serializer;

  localparam int unsigned W = 16;

`ifdef PISO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  typedef struct packed {
    logic b;
    logic l;
    logic p;
  } sb_t;

  typedef struct {
    logic [W-1:0] din;
    logic [W-1:0] exp_word;
    logic         exp_par;
  } vec_t;

  logic clk;
  logic resetn;

  piso_serializer_if #(.DATA_WIDTH(W)) bus ();

  piso_serializer #(.DATA_WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  sb_t          sb[$];
  logic [W-1:0] got_q[$];
  logic         gotp_q[$];
  logic [W-1:0] sipo;
  int           nd;
  int           run;
  int           max_run;

  vec_t vecs[8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(string nm, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  // Output check first, then queue the word that the next edge accepts.
  always @(negedge clk) begin
    if (resetn) begin
      if (bus.dout_valid) begin
        run++;
        if (run > max_run) max_run = run;
        if (sb.size() == 0) begin
          chk("unexpected_bit", 32'd1, 32'd0);
        end else begin
          sb_t e;
          e = sb.pop_front();
          chk("dout", 32'(bus.dout), 32'(e.b));
          chk("last", 32'(bus.last), 32'(e.l));
          if (!e.p) begin
            sipo = {sipo[W-2:0], bus.dout};
            nd++;
            if (nd == W) begin
              got_q.push_back(sipo);
              nd = 0;
            end
          end else begin
            gotp_q.push_back(bus.dout);
          end
        end
      end else begin
        run = 0;
        chk("idle_dout", 32'(bus.dout), 32'd0);
        chk("idle_last", 32'(bus.last), 32'd0);
      end
      if (bus.din_valid && bus.din_ready) begin
        for (int i = W - 1; i >= 0; i--) begin
          sb_t e;
          e.b = bus.din[i];
          e.l = (i == 0) && !PAR;
          e.p = 1'b0;
          sb.push_back(e);
        end
        if (PAR) begin
          sb_t e;
          e.b = ^bus.din;
          e.l = 1'b1;
          e.p = 1'b1;
          sb.push_back(e);
        end
      end
    end
  end

  task automatic flush();
    sb.delete();
    got_q.delete();
    gotp_q.delete();
    sipo = '0;
    nd   = 0;
    run  = 0;
  endtask

  task automatic wait_accept(string nm);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = bus.din_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) chk({nm, "_accept_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic send(logic [W-1:0] w);
    bus.din       = w;
    bus.din_valid = 1'b1;
    wait_accept("send");
    bus.din_valid = 1'b0;
    bus.din       = W'($urandom);
  endtask

  task automatic wait_word(string nm, logic [W-1:0] exp,
                           logic exp_par);
    for (int n = 0; n < 200 && got_q.size() == 0; n++)
      @(negedge clk);
    if (got_q.size() == 0) begin
      chk({nm, "_word_timeout"}, 32'd1, 32'd0);
    end else begin
      chk({nm, "_word"}, 32'(got_q.pop_front()), 32'(exp));
    end
`ifdef PISO_PARITY_EN
    for (int n = 0; n < 20 && gotp_q.size() == 0; n++)
      @(negedge clk);
    if (gotp_q.size() == 0) begin
      chk({nm, "_par_timeout"}, 32'd1, 32'd0);
    end else begin
      chk({nm, "_par"}, 32'(gotp_q.pop_front()),
          32'(exp_par));
    end
`else
    if (exp_par === 1'bx) chk({nm, "_x"}, 32'd1, 32'd0);
`endif
  endtask

  initial begin
    vecs[0] = '{16'hA5C3, 16'hA5C3, 1'b0};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 1'b0};
    vecs[2] = '{16'h0001, 16'h0001, 1'b1};
    vecs[3] = '{16'h1234, 16'h1234, 1'b1};
    vecs[4] = '{16'h00FF, 16'h00FF, 1'b0};
    vecs[5] = '{16'h0007, 16'h0007, 1'b1};
    vecs[6] = '{16'h0003, 16'h0003, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b1};

    flush();
    max_run       = 0;
    resetn        = 1'b0;
    bus.din       = '0;
    bus.din_valid = 1'b0;

    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
      chk("rst_dout", 32'(bus.dout), 32'd0);
      chk("rst_last", 32'(bus.last), 32'd0);
      chk("rst_din_ready", 32'(bus.din_ready), 32'd1);
    end
    @(posedge clk);
    #3 resetn = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(bus.din_ready), 32'd1);
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      send(vecs[i].din);
      wait_word("vec", vecs[i].exp_word, vecs[i].exp_par);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
    end

    // Back-to-back: valid held across the word boundary.
    max_run       = 0;
    bus.din       = 16'hFFFF;
    bus.din_valid = 1'b1;
    wait_accept("b2b0");
    bus.din       = 16'h0001;
    wait_accept("b2b1");
    bus.din_valid = 1'b0;
    wait_word("b2b_a", 16'hFFFF, 1'b0);
    wait_word("b2b_b", 16'h0001, 1'b1);
    repeat (3) @(negedge clk);
    chk("b2b_run", 32'(max_run), PAR ? 32'd34 : 32'd32);
    @(posedge clk);
    #1;

    // Backpressure: din churns mid-word while valid stays high.
    send(16'hA5C3);
    bus.din_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bus.din = W'($urandom);
      @(negedge clk);
      chk("bp_ready", 32'(bus.din_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.din_valid = 1'b0;
    wait_word("bp", 16'hA5C3, 1'b0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;

    // Reset in the middle of a word, away from any clock edge.
    send(16'h1234);
    repeat (5) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.dout_valid), 32'd0);
    chk("mid_rst_dout", 32'(bus.dout), 32'd0);
    chk("mid_rst_last", 32'(bus.last), 32'd0);
    chk("mid_rst_ready", 32'(bus.din_ready), 32'd1);
    flush();
    repeat (2) @(posedge clk);
    #3 resetn = 1'b1;
    @(posedge clk);
    #1;
    send(16'h00FF);
    wait_word("post_rst", 16'h00FF, 1'b0);
    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("got_empty", 32'(got_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out shift register: the transmit end of the team's serial-in parallel-out shift register link. Accepts a DATA_WIDTH-bit word over a valid/ready handshake and drives it out one bit per clock, MSB first. A downstream SIPO of equal width sampling `dout` while `dout_valid` is high holds the original word after the last bit. Supports back-to-back words with no idle cycle.

## Interface
- DATA_WIDTH, 16: word width in bits; legal range 2 to 64.
- clk  input  1  rising-edge clock.
- resetn  input  1  asynchronous, active-low reset.
- din  input  DATA_WIDTH  parallel word to serialize.
- din_valid  input  1  `din` holds a word.
- din_ready  output  1  block accepts `din` this cycle.
- dout  output  1  serial data bit, registered.
- dout_valid  output  1  `dout` carries a bit of a word, registered.
- last  output  1  high with the final bit of each word, registered.

## Operation
- FSM states: IDLE and SHIFT, plus PARITY when `PISO_PARITY_EN` is defined.
- Accept occurs on a clock edge where `din_valid && din_ready` is high.
- On accept:
  - Shift register loads `din`.
  - Bit counter loads 0.
  - State goes to SHIFT.
  - `dout` = din[DATA_WIDTH-1] and `dout_valid` = 1 from the next cycle.
- SHIFT, each cycle:
  - Shift register shifts left by one.
  - `dout` = the next MSB.
  - Counter increments.
- Counter width is $clog2(DATA_WIDTH). Counter is never compared beyond DATA_WIDTH-1, so it does not wrap.
- `last` = 1 when counter == DATA_WIDTH-1 (final data bit), parity disabled.
- `din_ready` is combinational from state:
  - 1 in IDLE.
  - 1 in the final-bit cycle of SHIFT (parity disabled).
  - 0 otherwise.
- `din_valid` is ignored whenever `din_ready` = 0. The held word is never overwritten.
- After the final bit:
  - Accept in the same cycle: reload, stay in SHIFT. First bit of the new word follows with no gap.
  - No accept: go to IDLE. `dout_valid` = 0, `last` = 0, `dout` = 0.
- `din` is sampled only on the accept edge. Later changes to `din` have no effect.

## Timing
- Reset (async, any time): state = IDLE, shift register = 0, counter = 0, `dout` = 0, `dout_valid` = 0, `last` = 0.
- Outputs clear immediately on reset assertion, not at the next edge.
- A partially sent word is discarded. Transmission never resumes after reset.
- `din_ready` = 1 while in reset. No accept can occur while resetn = 0.
- Latency: word accepted at edge k → bit i (MSB = bit 0) is valid in cycle k+1+i.
- Final data bit is in cycle k+DATA_WIDTH.
- Throughput: one word per DATA_WIDTH cycles, or DATA_WIDTH+1 with parity.
- Accept coinciding with the final bit: the new word's MSB is in the cycle immediately after.

## Configuration
- `PISO_PARITY_EN` undefined:
  - Exactly DATA_WIDTH bits per word.
  - `last` is on the final data bit.
- `PISO_PARITY_EN` defined:
  - After the final data bit, the FSM enters PARITY for one cycle.
  - `dout` = XOR of the whole word (even parity), `dout_valid` = 1, `last` = 1.
  - `last` stays 0 on data bits.
  - `din_ready` = 1 in PARITY (not on the final data bit), so back-to-back streaming resumes directly after the parity bit.
  - Parity is computed from `din` at accept and held in a register.

## Structure
- Package `piso_pkg` holds:
  - the state enum typedef (IDLE, SHIFT, PARITY), with the PARITY encoding present regardless of the macro;
  - the default width localparam.
- Single module, no sub-module. Counter, shift register and parity register are inline.

## Test plan
- Reset then idle: resetn low 2 cycles, din_valid = 0 → `dout_valid` = 0, `dout` = 0, `last` = 0, `din_ready` = 1 throughout.
- Single word: accept 16'hA5C3 → `dout` sequence 1010_0101_1100_0011 over 16 cycles, `last` high only on the 16th. A SIPO model fed the stream holds 16'hA5C3.
- Back-to-back: 16'hFFFF then 16'h0001 with din_valid held high → 32 contiguous `dout_valid` cycles. SIPO reads 16'hFFFF then 16'h0001.
- Backpressure: din_valid high with a changing `din` mid-word → `din_ready` low, mid-word changes ignored, output unchanged.
- Reset mid-word: resetn low after 5 bits of 16'h1234 → `dout_valid` drops without waiting for a clock edge. Next accepted 16'h00FF serializes cleanly.
- With `PISO_PARITY_EN`: accept 16'h0007 → 16 data bits, then a parity bit = 1 with `last` = 1. 16'h0003 → parity bit = 0.
